// File: rtl/decoder_scan_n.sv
// One-hot decoder with direct select, continuous scan and single-sweep modes.
// Every output is a flop; a position is held for dwell+1 cycles while scanning or sweeping.
module decoder_scan_n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  localparam int N      = 2**SEL_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic [SEL_W-1:0]   in_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               start_i,
  output logic [N-1:0]       out_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               wrap_o,
  output logic               done_o,
  output logic               busy_o
);

  // state      | meaning
  // IDLE       | disabled or reserved mode, all outputs inactive
  // DIRECT     | out follows one-hot(in) with one cycle of latency
  // SCAN       | cycle through positions forever, wrap pulse on return to 0
  // SWEEP_WAIT | armed, waiting for a start request
  // SWEEP_RUN  | one pass 0..N-1, done pulse at the end
  typedef enum logic [2:0] {IDLE, DIRECT, SCAN, SWEEP_WAIT, SWEEP_RUN} state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   pos_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [N-1:0]       out_q;
  logic [SEL_W-1:0]   sel_q;
  logic               wrap_q, done_q, busy_q;

  state_e             entry_d;
  logic               mode_match_d;
  logic               dwell_hit_d;
  logic               last_pos_d;
  logic [SEL_W-1:0]   pos_inc_d;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    entry_d      = IDLE;
    mode_match_d = 1'b0;
    case (mode_i)
      2'b00:   entry_d = DIRECT;
      2'b01:   entry_d = SCAN;
      2'b10:   entry_d = SWEEP_WAIT;
      default: entry_d = IDLE;
    endcase
    case (state_q)
      DIRECT:                mode_match_d = (mode_i == 2'b00);
      SCAN:                  mode_match_d = (mode_i == 2'b01);
      SWEEP_WAIT, SWEEP_RUN: mode_match_d = (mode_i == 2'b10);
      default:               mode_match_d = 1'b0;
    endcase
  end

  // Live compare: lowering dwell below the running count advances on the next edge.
  assign dwell_hit_d = (cnt_q >= dwell_i);
  assign last_pos_d  = (pos_q == SEL_W'(N-1));
  assign pos_inc_d   = pos_q + SEL_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (!en_i || mode_i == 2'b11) begin
        state_q <= IDLE;
        pos_q   <= '0;
        cnt_q   <= '0;
        out_q   <= '0;
        sel_q   <= '0;
        busy_q  <= 1'b0;
      end else if (!mode_match_d) begin
        // Entry from IDLE or a mode switch; an interrupted sweep ends silently.
        state_q <= entry_d;
        pos_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        if (entry_d == DIRECT) begin
          out_q <= onehot(in_i);
          sel_q <= in_i;
        end else if (entry_d == SCAN) begin
          out_q <= onehot('0);
          sel_q <= '0;
        end else begin
          out_q <= '0;
          sel_q <= '0;
        end
      end else begin
        case (state_q)
          DIRECT: begin
            out_q <= onehot(in_i);
            sel_q <= in_i;
          end
          SCAN: begin
            if (dwell_hit_d) begin
              pos_q  <= pos_inc_d;
              cnt_q  <= '0;
              out_q  <= onehot(pos_inc_d);
              sel_q  <= pos_inc_d;
              wrap_q <= last_pos_d;
            end else begin
              cnt_q <= cnt_q + DWELL_W'(1);
            end
          end
          SWEEP_WAIT: begin
            // A start coinciding with the done pulse is not a new request.
            if (start_i && !done_q) begin
              state_q <= SWEEP_RUN;
              pos_q   <= '0;
              cnt_q   <= '0;
              out_q   <= onehot('0);
              sel_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          SWEEP_RUN: begin
            if (dwell_hit_d) begin
              cnt_q <= '0;
              if (last_pos_d) begin
                state_q <= SWEEP_WAIT;
                pos_q   <= '0;
                out_q   <= '0;
                sel_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                pos_q <= pos_inc_d;
                out_q <= onehot(pos_inc_d);
                sel_q <= pos_inc_d;
              end
            end else begin
              cnt_q <= cnt_q + DWELL_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_o  = out_q;
  assign sel_o  = sel_q;
  assign wrap_o = wrap_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: doc/decoder_scan_n.md
DECODER_SCAN_N -- requirements
Module: decoder_scan_n

Interface
REQ-001 Parameter SEL_W, default 3, select width; output count N = 2**SEL_W.
REQ-002 Parameter DWELL_W, default 8, width of dwell-time input and internal dwell counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  block enable; low forces outputs inactive.
REQ-006 mode  input  2  00 direct, 01 continuous scan, 10 single sweep, 11 reserved.
REQ-007 in  input  SEL_W  select code used in direct mode.
REQ-008 dwell  input  DWELL_W  scan hold time; each position is held dwell+1 cycles.
REQ-009 start  input  1  single-cycle request that begins a sweep in mode 10.
REQ-010 out  output  N  registered one-hot decode; all-zero when inactive.
REQ-011 sel  output  SEL_W  registered index of the active out bit; 0 when inactive.
REQ-012 wrap  output  1  one-cycle pulse, continuous scan returned from N-1 to 0.
REQ-013 done  output  1  one-cycle pulse, single sweep completed.
REQ-014 busy  output  1  high while a sweep is running.

Function
REQ-015 FSM states SHALL be IDLE, DIRECT, SCAN, SWEEP_WAIT, SWEEP_RUN.
REQ-016 en=0 or mode=11 SHALL force IDLE on the next edge: out=0, sel=0, position and dwell counter cleared, wrap/done/busy low.
REQ-017 From IDLE, with en=1, the next edge SHALL enter DIRECT, SCAN or SWEEP_WAIT per mode.
REQ-018 A mode change while en=1 SHALL take effect on the next edge, entering the new state with position and dwell counter cleared; an aborted sweep SHALL NOT pulse done.
REQ-019 DIRECT: out SHALL equal one-hot(in) and sel SHALL equal in, one cycle after in is sampled; out is never multi-hot.
REQ-020 SCAN: on entry, out SHALL show position 0; the dwell counter SHALL increment each cycle and the position advances when counter >= dwell (live compare), after which the counter clears.
REQ-021 SCAN: advancing from N-1 SHALL wrap to 0, and wrap SHALL be high in exactly the cycle sel first reads 0 after N-1.
REQ-022 dwell=0 SHALL advance the position every cycle; lowering dwell below the current count SHALL advance on the next edge.
REQ-023 SWEEP_WAIT: out=0, busy=0; start=1 SHALL enter SWEEP_RUN with position 0 visible and busy=1 on the next edge.
REQ-024 SWEEP_RUN: positions SHALL step 0..N-1 under the REQ-020 dwell rule; start SHALL be ignored while running.
REQ-025 When position N-1 completes its dwell, the next edge SHALL return to SWEEP_WAIT with out=0, busy=0 and done=1 for one cycle.
REQ-026 start in the same cycle as the done pulse SHALL be ignored; a new sweep requires start while in SWEEP_WAIT.
REQ-027 wrap and done SHALL never both be high; out SHALL always be one-hot or all-zero.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, out=0, sel=0, wrap=0, done=0, busy=0, counters 0, regardless of clk.
REQ-029 Reset asserted mid-scan or mid-sweep SHALL abort with no wrap or done pulse; after release, operation resumes from IDLE per REQ-017.

Verification
REQ-030 Direct: en=1, mode=00, in=5 -> next cycle out=8'b0010_0000, sel=5; in=0 -> out=8'b0000_0001.
REQ-031 Scan: mode=01, dwell=2 -> each sel held 3 cycles, sequence 0..7,0; wrap high only in the first cycle of the returning sel=0, period 24 cycles.
REQ-032 Sweep: mode=10, dwell=0, start pulse -> sel 0..7 on consecutive cycles with busy=1, then out=0, busy=0, done=1 for one cycle; a second start mid-sweep has no effect.
REQ-033 Live dwell: scan with dwell=10 at count 6, dwell changed to 3 -> position advances on the next edge.
REQ-034 Abort: en dropped at sel=4 during sweep -> next cycle out=0, busy=0, no done pulse; rst_n pulsed mid-scan -> outputs zero immediately and asynchronously.
REQ-035 Parameter: SEL_W=4, mode=01, dwell=0 -> 16-position scan, wrap every 16 cycles, out always one-hot.
